// File: rtl/booth_pkg.sv
// Shared constants for the radix-4 Booth multiplier datapath.
//   WIDTH   : operand width. The control sequence is fixed for 4 bits.
//   A_WIDTH : accumulator width. Two guard bits hold +/-2M sums.
//   P_WIDTH : product width.
package booth_pkg;

  localparam int WIDTH   = 4;
  localparam int A_WIDTH = WIDTH + 2;
  localparam int P_WIDTH = 2 * WIDTH;

endpackage : booth_pkg

// File: rtl/booth_addsub.sv
// Combinational accumulator update for one radix-4 Booth step.
// The result is A +/- M or A +/- 2M, modulo 2^(WIDTH+2).
// Ports:
//   a      : current accumulator, WIDTH+2 bits
//   m      : signed multiplicand, WIDTH bits
//   resta  : 1 = subtract, 0 = add
//   mom2   : 1 = use 2M, 0 = use M
//   a_next : updated accumulator, WIDTH+2 bits
module booth_addsub #(
  parameter int WIDTH = booth_pkg::WIDTH
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             resta,
  input  logic             mom2,
  output logic [WIDTH+1:0] a_next
);

  logic [WIDTH+1:0] operand;

  // NOTE: every variable written in always_comb gets a value on every path.
  // Otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    operand = {{2{m[WIDTH-1]}}, m};
    if (mom2) begin
      operand = {m[WIDTH-1], m, 1'b0};
    end
    a_next = resta ? (a - operand) : (a + operand);
  end

endmodule : booth_addsub

// File: rtl/booth_datapath.sv
// Datapath for the radix-4 Booth signed multiplier.
// It holds M, A, Q and the Booth bit q_-1, and applies the control unit's strobes.
// It returns the recoding bits to the control unit.
// It captures the product with a one-cycle Valido pulse on the rising edge of Fin.
// Ports:
//   clk, reset                   : clock; synchronous active-low reset
//   Multiplicando, Multiplicador : signed operands, sampled on Carga_QM
//   Carga_QM, Carga_A, Resta, MoM2, Desplaza_AQ, Fin : control strobes
//   q1, q0, q_menos1             : recoding bits Q[1], Q[0] and q_-1
//   Producto, Valido             : registered product and its update pulse
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = booth_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   Multiplicando,
  input  logic [WIDTH-1:0]   Multiplicador,
  input  logic               Carga_QM,
  input  logic               Carga_A,
  input  logic               Resta,
  input  logic               MoM2,
  input  logic               Desplaza_AQ,
  input  logic               Fin,
  output logic               q1,
  output logic               q0,
  output logic               q_menos1,
  output logic [2*WIDTH-1:0] Producto,
  output logic               Valido
);

  localparam int AW = WIDTH + 2;

  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] q_r;
  logic [AW-1:0]    a_r;
  logic             qm1_r;
  logic             fin_d;
  logic [AW-1:0]    a_sum;

  booth_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a      (a_r),
    .m      (m_r),
    .resta  (Resta),
    .mom2   (MoM2),
    .a_next (a_sum)
  );

  // NOTE: sequential state uses non-blocking assignments.
  // All registers then sample their pre-edge values, which the shift below relies on.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_r      <= '0;
      q_r      <= '0;
      a_r      <= '0;
      qm1_r    <= 1'b0;
      fin_d    <= 1'b0;
      Producto <= '0;
      Valido   <= 1'b0;
    end else begin
      fin_d  <= Fin;
      Valido <= Fin & ~fin_d;
      if (Fin && !fin_d) begin
        Producto <= {a_r[WIDTH-1:0], q_r};
      end

      // The strobes are priority-encoded. The load wins over the add, and the add wins over the shift.
      if (Carga_QM) begin
        m_r   <= Multiplicando;
        q_r   <= Multiplicador;
        a_r   <= '0;
        qm1_r <= 1'b0;
      end else if (Carga_A) begin
        a_r <= a_sum;
      end else if (Desplaza_AQ) begin
        {a_r, q_r, qm1_r} <= {a_r[AW-1], a_r, q_r};
      end
    end
  end

  assign q1       = q_r[1];
  assign q0       = q_r[0];
  assign q_menos1 = qm1_r;

endmodule : booth_datapath

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath.
// It uses a table of multiplications with hand-computed products and models the control unit.
// Hand-written sequences cover strobe priority, a held Fin, and reset during an operation.
module tb_booth_datapath;
  import booth_pkg::*;

  logic               clk;
  logic               reset;
  logic [WIDTH-1:0]   Multiplicando;
  logic [WIDTH-1:0]   Multiplicador;
  logic               Carga_QM, Carga_A, Resta, MoM2, Desplaza_AQ, Fin;
  logic               q1, q0, q_menos1;
  logic [P_WIDTH-1:0] Producto;
  logic               Valido;

  int total = 0;
  int bad   = 0;

  booth_datapath #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .Multiplicando (Multiplicando),
    .Multiplicador (Multiplicador),
    .Carga_QM      (Carga_QM),
    .Carga_A       (Carga_A),
    .Resta         (Resta),
    .MoM2          (MoM2),
    .Desplaza_AQ   (Desplaza_AQ),
    .Fin           (Fin),
    .q1            (q1),
    .q0            (q0),
    .q_menos1      (q_menos1),
    .Producto      (Producto),
    .Valido        (Valido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mc;
    logic [3:0] mp;
    logic [7:0] prod;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one cycle of strobes, then samples 1 ns after the rising edge.
  task automatic step(input logic cqm, input logic ca, input logic rs,
                      input logic m2, input logic sh, input logic fn);
    Carga_QM    = cqm;
    Carga_A     = ca;
    Resta       = rs;
    MoM2        = m2;
    Desplaza_AQ = sh;
    Fin         = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Control-unit model. Booth digits come from the bench's own copy of the multiplier.
  task automatic run_mult(input logic [3:0] mc, input logic [3:0] mp,
                          input logic [7:0] exp, input string tag);
    logic [4:0] ext;
    logic [2:0] tri_bits;
    int         vcount;
    vcount        = 0;
    ext           = {mp, 1'b0};
    Multiplicando = mc;
    Multiplicador = mp;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vcount += int'(Valido);
    for (int i = 0; i < 2; i++) begin
      tri_bits = ext[2*i +: 3];
      check({tag, "_qbits"}, {29'd0, q1, q0, q_menos1}, {29'd0, tri_bits});
      case (tri_bits)
        3'b001, 3'b010: step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        3'b011:         step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        3'b100:         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        3'b101, 3'b110: step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        default:        idle();
      endcase
      vcount += int'(Valido);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vcount += int'(Valido);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      vcount += int'(Valido);
    end
    check({tag, "_early_valid"}, 32'(vcount), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check({tag, "_valid"}, {31'd0, Valido}, 32'd1);
    check({tag, "_prod"}, {24'd0, Producto}, {24'd0, exp});
    idle();
    check({tag, "_valid_drop"}, {31'd0, Valido}, 32'd0);
  endtask

  initial begin
    int vcount;

    vecs[0] = '{4'd3,  4'd5,  8'h0F};
    vecs[1] = '{4'h8,  4'h8,  8'h40};
    vecs[2] = '{4'd7,  4'h8,  8'hC8};
    vecs[3] = '{4'hF,  4'hF,  8'h01};
    vecs[4] = '{4'd0,  4'h9,  8'h00};
    vecs[5] = '{4'h8,  4'd7,  8'hC8};
    vecs[6] = '{4'd5,  4'hD,  8'hF1};
    vecs[7] = '{4'h9,  4'h8,  8'h38};

    reset         = 1'b0;
    Multiplicando = '0;
    Multiplicador = '0;
    Carga_QM = 0; Carga_A = 0; Resta = 0; MoM2 = 0; Desplaza_AQ = 0; Fin = 0;

    // Reset overrides random strobes.
    Multiplicando = 4'h7;
    Multiplicador = 4'h7;
    for (int i = 0; i < 2; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    check("rst_a", 32'(dut.a_r), 32'd0);
    check("rst_qbits", {29'd0, q1, q0, q_menos1}, 32'd0);
    check("rst_prod", {24'd0, Producto}, 32'd0);
    check("rst_valid", {31'd0, Valido}, 32'd0);
    reset = 1'b1;
    idle();

    // Load, then subtract 2M.
    Multiplicando = 4'd3;
    Multiplicador = 4'd5;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_q", 32'(dut.q_r), 32'h5);
    check("load_qbits", {29'd0, q1, q0, q_menos1}, {29'd0, 3'b010});
    check("load_a", 32'(dut.a_r), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sub2m_a", 32'(dut.a_r), 32'(6'b111010));

    // Table-driven full multiplications.
    foreach (vecs[k]) begin
      run_mult(vecs[k].mc, vecs[k].mp, vecs[k].prod, $sformatf("vec%0d", k));
    end

    // Load wins over add and shift.
    Multiplicando = 4'd3;
    Multiplicador = 4'd6;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    Multiplicando = 4'd2;
    Multiplicador = 4'd5;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("prio_load_a", 32'(dut.a_r), 32'd0);
    check("prio_load_q", 32'(dut.q_r), 32'h5);
    check("prio_load_qm1", {31'd0, q_menos1}, 32'd0);
    // Add wins over shift. A = 0 + 2 and Q is unchanged.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("prio_add_a", 32'(dut.a_r), 32'd2);
    check("prio_add_q", 32'(dut.q_r), 32'h5);

    // A held Fin gives exactly one pulse, and Producto stays stable.
    run_mult(4'd3, 4'd5, 8'h0F, "pre_hold");
    vcount = 0;
    Multiplicando = 4'd7;
    Multiplicador = 4'd7;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      vcount += int'(Valido);
    end
    check("hold_pulses", 32'(vcount), 32'd1);
    check("hold_prod", {24'd0, Producto}, 32'h00000007);
    idle();
    check("hold_valid_low", {31'd0, Valido}, 32'd0);

    // Reset after the first shift aborts the operation. Then restart.
    Multiplicando = 4'd3;
    Multiplicador = 4'd5;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("abort_a", 32'(dut.a_r), 32'd0);
    check("abort_m", 32'(dut.m_r), 32'd0);
    check("abort_qbits", {29'd0, q1, q0, q_menos1}, 32'd0);
    check("abort_prod", {24'd0, Producto}, 32'd0);
    check("abort_valid", {31'd0, Valido}, 32'd0);
    reset = 1'b1;
    idle();
    check("abort_no_valid", {31'd0, Valido}, 32'd0);
    run_mult(4'd3, 4'd5, 8'h0F, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_booth_datapath

// File: doc/booth_datapath.md
Name: booth_datapath

Overview:
Datapath for the radix-4 Booth signed multiplier. It consumes the control strobes of the multiplier control unit (Carga_QM, Carga_A, Resta, MoM2, Desplaza_AQ, Fin). It returns the recoding bits q1/q0/q_menos1 to that unit. Holds registers M, A and Q plus the Booth bit q_-1, performs add/sub of ±M/±2M and the arithmetic right shifts, and captures the final product with a one-cycle valid pulse.

Parameters:
WIDTH, 4, operand width in bits. The control sequence (2 Booth iterations × 2 single-bit shifts) is fixed for WIDTH=4; other values are unsupported.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
Multiplicando  input  WIDTH  signed multiplicand, sampled on Carga_QM
Multiplicador  input  WIDTH  signed multiplier, sampled on Carga_QM
Carga_QM  input  1  load operands, clear A and q_-1
Carga_A  input  1  A <= A ± M or A ± 2M
Resta  input  1  1 = subtract, 0 = add (meaningful with Carga_A)
MoM2  input  1  1 = use 2M, 0 = use M (meaningful with Carga_A)
Desplaza_AQ  input  1  arithmetic shift right by 1 of {A,Q,q_-1}
Fin  input  1  control unit in final state
q1  output  1  Q[1]
q0  output  1  Q[0]
q_menos1  output  1  q_-1 register
Producto  output  2*WIDTH  registered signed product
Valido  output  1  one-cycle pulse when Producto updates

Behaviour:
- Register widths: M = WIDTH; Q = WIDTH; A = WIDTH+2 (holds ±2M sums without overflow); q_-1 = 1 bit; Producto = 2*WIDTH; fin_d = 1 bit (delayed Fin).
- reset=0 at a clock edge: A, M, Q, q_-1, Producto, Valido and fin_d all go to 0, overriding every strobe. Reset mid-multiplication aborts the operation; no Valido is issued.
- Strobe priority per cycle: Carga_QM > Carga_A > Desplaza_AQ. If none is asserted, all registers hold.
- Carga_QM: M <= Multiplicando; Q <= Multiplicador; A <= 0; q_-1 <= 0.
- Carga_A: operand = sign-extend(M) to WIDTH+2, shifted left 1 when MoM2=1.
  - A <= A − operand if Resta=1, otherwise A + operand.
  - Result is modulo 2^(WIDTH+2). M, Q and q_-1 are unchanged.
- Desplaza_AQ: {A,Q,q_-1} <= {A[MSB], A, Q} truncated to the same width.
  - Sign bit A[MSB] is replicated; q_-1 takes the old Q[0].
- q1, q0, q_menos1 are combinational from the registers. They are valid in the same cycle the control unit samples them.
- Product capture:
  - fin_d <= Fin every cycle.
  - When Fin=1 and fin_d=0: Producto <= {A[WIDTH-1:0], Q} and Valido <= 1. Otherwise Valido <= 0.
  - Fin held high for many cycles gives exactly one pulse. Producto holds until the next capture or reset.
- Latency: Valido is asserted 1 cycle after Fin rises, i.e. 8 cycles after the Carga_QM cycle with the standard control sequence.
- Boundaries:
  - −8×−8 = +64 fits in 8-bit signed.
  - The A intermediate after −2M with M=−8 is +16, which fits in 6-bit signed.
  - No saturation anywhere.

Decomposition:
- Package booth_pkg: WIDTH constant, derived A_WIDTH = WIDTH+2, P_WIDTH = 2*WIDTH.
- One sub-module, booth_addsub: combinational A_WIDTH adder/subtractor taking A, M, Resta, MoM2 and returning the new A. It is instantiated once inside booth_datapath.

Test Plan:
- reset=0 held 2 cycles with random strobes -> A=0, Q=0, q_menos1=0, Producto=0, Valido=0; then release reset.
- Carga_QM with Multiplicando=3, Multiplicador=5 -> Q=0101, q1=0, q0=1, q_menos1=0, A=0. Next cycle Carga_A, Resta=1, MoM2=1 -> A=6'b111010 (−6).
- Full sequence driven by the control unit:
  - 3×5 -> Producto=8'h0F with a single Valido pulse.
  - −8×−8 -> Producto=8'h40.
  - 7×−8 -> Producto=8'hC8.
  - −1×−1 -> Producto=8'h01.
  - 0×−7 -> Producto=8'h00.
- Carga_QM, Carga_A and Desplaza_AQ asserted together -> only the load occurs. Carga_A with Desplaza_AQ -> only the add occurs.
- Fin held high 20 cycles -> Valido high for exactly 1 cycle and Producto stable.
- reset=0 asserted at the cycle after the first shift -> all registers 0 next edge. Restarting with 3×5 still yields 8'h0F.
